// File: rtl/vision_pkg.sv
// Shared types for the vision pipeline: pixel width, direction codes,
// output word layout, and the Sobel tap helper.
package vision_pkg;
  localparam int PIX_W = 8;

  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  typedef struct packed {
    logic [1:0]       dir;
    logic [PIX_W-1:0] mag;
  } sobel_word_t;

  typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_EDGE, ST_FLUSH} sobel_state_t;

  // 1-2-1 weighted sum of three taps, 12 bits so differences wrap as two's complement
  function automatic logic [11:0] tap_sum(input logic [PIX_W-1:0] a, b, c);
    return {4'd0, a} + {3'd0, b, 1'b0} + {4'd0, c};
  endfunction
endpackage

// File: rtl/line_buffer_2.sv
// Two chained row delay lines addressed by column: o_row_y is the previous row,
// o_row_ym1 the one before it, both at column i_addr.
module line_buffer_2 import vision_pkg::*; #(
  parameter int IMG_WIDTH = 1920
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(IMG_WIDTH)-1:0] i_addr,
  input  logic [PIX_W-1:0]             i_din,
  output logic [PIX_W-1:0]             o_row_y,
  output logic [PIX_W-1:0]             o_row_ym1
);
  logic [PIX_W-1:0] r_line0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_line1 [IMG_WIDTH];

  assign o_row_y   = r_line0[i_addr];
  assign o_row_ym1 = r_line1[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_line0[i_addr] <= i_din;
      r_line1[i_addr] <= r_line0[i_addr];
    end
  end
endmodule

// File: rtl/sobel_stage.sv
// 3x3 Sobel on a raster stream with clamp padding; emits {dir, saturated mag}
// per pixel in input raster order through a 3-stage stallable pipeline.
module sobel_stage import vision_pkg::*; #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic             s_tuser,
  output logic [9:0]       m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic             err_sync
);
  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [XW-1:0] X_EDGE = XW'(IMG_WIDTH);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  sobel_state_t  r_state, w_state_nxt;
  logic [XW-1:0] r_x, w_x_nxt;
  logic [YW-1:0] r_y, w_y_nxt;
  logic          w_en, w_rdy, w_acc, w_step;

  always_comb begin
    w_en   = !(m_tvalid && !m_tready);
    w_rdy  = w_en && !rst && (r_state == ST_FILL || r_state == ST_STREAM);
    w_acc  = w_rdy && s_tvalid;
    w_step = (r_state == ST_STREAM && w_acc) ||
             (w_en && (r_state == ST_EDGE || r_state == ST_FLUSH));
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    unique case (r_state)
      ST_FILL: if (w_acc) begin
        if (r_x == X_LAST) begin
          w_x_nxt     = '0;
          w_y_nxt     = YW'(1);
          w_state_nxt = ST_STREAM;
        end else w_x_nxt = r_x + 1'b1;
      end
      // x parks at W during EDGE so the step logic sees it as the replicate column
      ST_STREAM: if (w_acc) begin
        if (r_x == X_LAST) begin
          w_x_nxt     = X_EDGE;
          w_state_nxt = ST_EDGE;
        end else w_x_nxt = r_x + 1'b1;
      end
      ST_EDGE: if (w_en) begin
        w_x_nxt = '0;
        if (r_y == Y_LAST) w_state_nxt = ST_FLUSH;
        else begin
          w_y_nxt     = r_y + 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_FLUSH: if (w_en) begin
        if (r_x == X_EDGE) begin
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = ST_FILL;
        end else w_x_nxt = r_x + 1'b1;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  assign s_tready = w_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FILL;
      r_x      <= '0;
      r_y      <= '0;
      err_sync <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      if (w_acc && ((s_tuser != (r_x == '0 && r_y == '0)) || (s_tlast != (r_x == X_LAST))))
        err_sync <= 1'b1;
    end
  end

  logic [AW-1:0]    w_addr;
  logic [PIX_W-1:0] w_lb_y, w_lb_ym1;

  assign w_addr = (r_x >= X_EDGE) ? AW'(IMG_WIDTH - 1) : r_x[AW-1:0];

  line_buffer_2 #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
    .clk      (clk),
    .i_we     (w_acc),
    .i_addr   (w_addr),
    .i_din    (s_tdata),
    .o_row_y  (w_lb_y),
    .o_row_ym1(w_lb_ym1)
  );

  // Stage 1: 3x3 window, r_win[row][col], row 0 = top, col 0 = left
  logic [2:0][2:0][PIX_W-1:0] r_win;
  logic [2:0][PIX_W-1:0]      w_new;
  logic [1:0]                 r_vld_pipe;
  logic                       r_last1, r_user1, r_last2, r_user2;

  always_comb begin
    w_new = '0;
    if (r_x == X_EDGE) begin
      for (int r = 0; r < 3; r++) w_new[r] = r_win[r][2];
    end else if (r_state == ST_FLUSH) begin
      w_new[0] = w_lb_ym1;
      w_new[1] = w_lb_y;
      w_new[2] = w_lb_y;
    end else begin
      w_new[0] = (r_y == YW'(1)) ? w_lb_y : w_lb_ym1;
      w_new[1] = w_lb_y;
      w_new[2] = s_tdata;
    end
  end

  // Stage 2: gradients as 12-bit two's complement
  logic [11:0] w_gx, w_gy, r_gx, r_gy;
  assign w_gx = tap_sum(r_win[0][2], r_win[1][2], r_win[2][2]) -
                tap_sum(r_win[0][0], r_win[1][0], r_win[2][0]);
  assign w_gy = tap_sum(r_win[2][0], r_win[2][1], r_win[2][2]) -
                tap_sum(r_win[0][0], r_win[0][1], r_win[0][2]);

  // Stage 3: |Gx|,|Gy| fit in 11 bits since |G| <= 1020
  logic [10:0] w_ax, w_ay, w_sum;
  logic [13:0] w_ax2, w_ax5, w_ay2, w_ay5;
  sobel_word_t w_word;

  always_comb begin
    w_ax  = r_gx[11] ? (~r_gx[10:0] + 11'd1) : r_gx[10:0];
    w_ay  = r_gy[11] ? (~r_gy[10:0] + 11'd1) : r_gy[10:0];
    w_sum = w_ax + w_ay;
    w_ax2 = {2'd0, w_ax, 1'b0};
    w_ay2 = {2'd0, w_ay, 1'b0};
    w_ax5 = {1'b0, w_ax, 2'b0} + {3'd0, w_ax};
    w_ay5 = {1'b0, w_ay, 2'b0} + {3'd0, w_ay};
    w_word.mag = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
    if (w_ay5 <= w_ax2)            w_word.dir = DIR_0;
    else if (w_ay2 >= w_ax5)       w_word.dir = DIR_90;
    else if (r_gx[11] == r_gy[11]) w_word.dir = DIR_45;
    else                           w_word.dir = DIR_135;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[0], w_step && (r_x != '0)};
      r_last1    <= (r_x == X_EDGE);
      r_user1    <= (r_x == XW'(1)) && (r_state == ST_STREAM) && (r_y == YW'(1));
      if (w_step) begin
        for (int r = 0; r < 3; r++) begin
          if (r_x == '0) begin
            r_win[r][0] <= w_new[r];
            r_win[r][1] <= w_new[r];
            r_win[r][2] <= w_new[r];
          end else begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= r_win[r][2];
            r_win[r][2] <= w_new[r];
          end
        end
      end
      r_gx    <= w_gx;
      r_gy    <= w_gy;
      r_last2 <= r_last1;
      r_user2 <= r_user1;
      m_tvalid <= r_vld_pipe[1];
      if (r_vld_pipe[1]) begin
        m_tdata <= w_word;
        m_tlast <= r_last2;
        m_tuser <= r_user2;
      end
    end
  end
endmodule

// File: tb/tb_sobel_stage.sv
// Scoreboard bench for sobel_stage on an 8x8 image: directed frames, backpressure,
// framing error and mid-frame reset.
module tb_sobel_stage;
  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b1;
  logic       s_tready, m_tvalid, m_tlast, m_tuser, err_sync;
  logic [9:0] m_tdata;

  sobel_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0, gap_cnt = 0;
  logic [11:0] exp_q[$];
  bit          chk_en = 1'b0, stall_en = 1'b0, prev_stall = 1'b0;
  logic [12:0] prev_word = '0;
  logic [11:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pix(input int mode, input int x, input int y);
    if (mode == 0) return 100;
    if (mode == 1) return (x >= 4) ? 255 : 0;
    if (mode == 2) return (y >= 4) ? 255 : 0;
    if (mode == 3) return x + y + 20;
    return x - y + 20;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // direct clamped-window reference, used for ramp border pixels
  function automatic logic [9:0] ref_word(input int mode, input int x, input int y);
    int p[3][3];
    int gx, gy, ax, ay, mag, d;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = pix(mode, clampi(x + c - 1, W - 1), clampi(y + r - 1, H - 1));
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = (ax + ay > 255) ? 255 : ax + ay;
    if (5 * ay <= 2 * ax) d = 0;
    else if (2 * ay >= 5 * ax) d = 2;
    else if ((gx < 0) == (gy < 0)) d = 1;
    else d = 3;
    return {2'(d), 8'(mag)};
  endfunction

  function automatic logic [9:0] exp_word(input int mode, input int x, input int y);
    bit interior;
    interior = (x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2);
    if (mode == 0) return 10'd0;
    if (mode == 1) return (x == 3 || x == 4) ? {2'd0, 8'd255} : 10'd0;
    if (mode == 2) return (y == 3 || y == 4) ? {2'd2, 8'd255} : 10'd0;
    if (mode == 3) return interior ? {2'd1, 8'd16} : ref_word(mode, x, y);
    return interior ? {2'd3, 8'd16} : ref_word(mode, x, y);
  endfunction

  task automatic push_frame(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({(x == 0 && y == 0), (x == W - 1), exp_word(mode, x, y)});
  endtask

  task automatic send_frame(input int mode, input int err_beat, input int nbeats);
    int x, y, n;
    bit hs;
    for (int b = 0; b < nbeats; b++) begin
      x = b % W;
      y = b / W;
      if (stall_en)
        while ($urandom_range(0, 1) == 1) begin
          s_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      s_tvalid = 1'b1;
      s_tdata  = 8'(pix(mode, x, y));
      s_tuser  = (b == 0) || (b == err_beat);
      s_tlast  = (x == W - 1);
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 200) begin
        @(negedge clk);
        hs = s_tready;
        @(posedge clk); #1;
        n++;
      end
      if (!hs) chk("accept_timeout", 0, 1);
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int mode, input int err_beat);
    gap_cnt = 0;
    push_frame(mode);
    send_frame(mode, err_beat, W * H);
    wait_drain();
    chk("not_ready_cycles", gap_cnt, (H - 1) + (W + 1));
  endtask

  initial forever begin
    @(posedge clk); #1;
    m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = 1'b0;
    else begin
      if (!s_tready && !(m_tvalid && !m_tready)) gap_cnt++;
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, prev_word);
      if (chk_en && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("extra_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_word", {m_tuser, m_tlast, m_tdata}, e);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tvalid, m_tuser, m_tlast, m_tdata};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_err_sync", err_sync, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", s_tready, 1);
    @(posedge clk); #1;
    chk_en = 1'b1;

    run_frame(0, -1);
    chk("err_clean", err_sync, 0);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(3, -1);
    run_frame(4, -1);

    stall_en = 1'b1;
    run_frame(3, -1);
    run_frame(4, -1);
    stall_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("err_after_stall", err_sync, 0);

    run_frame(0, 4);
    chk("err_sync_set", err_sync, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_sync_cleared", err_sync, 0);

    chk_en = 1'b0;
    send_frame(0, -1, 20);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    rst = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
    run_frame(0, -1);
    chk("err_after_midrst", err_sync, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
